// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a 1024x32 main memory.
// Latency: gnt one cycle after the request edge, done ACCESS_LAT+1 cycles after it (out of range: 2).
// Backpressure: requests hold until gnt; inputs are ignored while busy. Define MEM_ARB_STATS_EN for grant counters.
module mem_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int ACCESS_LAT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  done0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  gcnt0,
  output logic [CNT_WIDTH-1:0]  gcnt1
`endif
);

  localparam int LW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  if (ACCESS_LAT < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("mem_access_arbiter: ACCESS_LAT and CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic                  rr_q, rr_d;        // preferred requester when both ask
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  done0_q, done0_d, done1_q, done1_d;
  logic                  resp_err_q, resp_err_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  busy_q, busy_d;

  logic                  sel, sel_we, sel_oor;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Arbitration choice, next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    resp_err_d  = 1'b0;
    mem_wr_en_d = 1'b0;

    sel       = (req0 && req1) ? rr_q : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_oor   = ({1'b0, sel_addr} >= DEPTH_EXT);

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = sel;
          rr_d    = ~sel;
          we_d    = sel_we;
          err_d   = sel_oor;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
          if (sel_oor) begin
            // Out of range skips memory; RESP waits one cycle so done lands after gnt.
            state_d = S_RESP;
            cnt_d   = LW'(1);
          end else begin
            addr_d      = sel_addr;
            wdata_d     = sel_wdata;
            state_d     = S_ACCESS;
            cnt_d       = LW'(ACCESS_LAT - 1);
            mem_wr_en_d = sel_we && (ACCESS_LAT == 1);
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_RESP;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          cnt_d       = cnt_q - LW'(1);
          mem_wr_en_d = we_q && (cnt_q == LW'(1));
        end
      end
      S_RESP: begin
        if (cnt_q != '0) begin
          cnt_d      = '0;
          done0_d    = ~owner_q;
          done1_d    = owner_q;
          resp_err_d = err_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output update; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      resp_err_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      resp_err_q  <= resp_err_d;
      mem_wr_en_q <= mem_wr_en_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign resp_err    = resp_err_q;
  assign mem_rd_addr = addr_q;
  assign mem_wr_addr = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign busy        = busy_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] gcnt0_q, gcnt1_q;

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt0_d && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + CNT_WIDTH'(1);
      if (gnt1_d && (gcnt1_q != '1)) gcnt1_q <= gcnt1_q + CNT_WIDTH'(1);
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`endif

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Two-requester arbiter and sequencer in front of the word-addressed main memory (1024 x 32, combinational read).
- Requester 0 is the L1 miss/fill path; requester 1 is the L2 fill/writeback path.
- Round-robin grant; one access in flight at a time.
- Models a fixed memory access latency.
- Produces a gated single-cycle write enable, so the memory never sees a spurious write.

Parameters:
ADDR_WIDTH, 32, requester/memory address width (word address)
DATA_WIDTH, 32, data word width
MEM_DEPTH, 1024, number of memory words; addresses >= MEM_DEPTH are out of range
ACCESS_LAT, 4, cycles spent in ACCESS per request (legal range >= 1)
CNT_WIDTH, 16, width of grant counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 request; held until gnt0
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_WIDTH  requester 0 word address
wdata0  in  DATA_WIDTH  requester 0 write data
gnt0  out  1  requester 0 granted, one-cycle pulse
done0  out  1  requester 0 access complete, one-cycle pulse
req1, we1, addr1, wdata1, gnt1, done1  (as above, requester 1)
rdata  out  DATA_WIDTH  read data; valid with done0/done1 of a read
resp_err  out  1  with done: address was out of range
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_wr_addr  out  ADDR_WIDTH  memory write address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wr_en  out  1  memory write strobe
mem_rdata  in  DATA_WIDTH  memory read data (combinational from mem_rd_addr)
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer points at requester 0.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - Sample req0/req1 each edge.
  - One requesting: grant it.
  - Both requesting: grant the one not granted last; requester 0 after reset.
  - On grant edge: latch we/addr/wdata and owner id; assert gnt for exactly the next cycle; update rr pointer.
  - In range: go to ACCESS with counter = ACCESS_LAT-1.
  - addr >= MEM_DEPTH: go directly to RESP with resp_err=1; no memory access.
- ACCESS:
  - Drive mem_rd_addr = mem_wr_addr = latched addr; mem_wdata = latched wdata.
  - Decrement counter each cycle.
  - When counter == 0: a read captures mem_rdata into rdata; a write asserts mem_wr_en for that single cycle only. Then go to RESP.
- RESP:
  - done of the owner high for one cycle; resp_err as determined at grant.
  - Then return to IDLE.
  - rdata holds its value until the next read completes.
- Latency: req sampled at edge E0 -> gnt high in cycle E0..E1 -> done high ACCESS_LAT+1 cycles after E0.
  - Out-of-range request: done high in cycle E1..E2.
  - Next grant no earlier than the edge ending RESP.
- Requester rules:
  - Requester must keep req/we/addr/wdata stable until it sees gnt, then deassert req.
  - req still high in the cycle after done is a new request.
  - Inputs are ignored outside IDLE.
- mem_wr_en is 0 in every cycle except the final ACCESS cycle of an in-range write.
- Reset mid-operation: state returns to IDLE immediately; no done is issued; a write is not performed unless mem_wr_en had already been sampled.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs gcnt0 and gcnt1 (CNT_WIDTH each) counting grants per requester, including out-of-range grants.
  - Counters saturate at all-ones and never wrap.
  - Cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Read, memory preloaded mem[i]=i: req0 read addr 5 at E0 -> gnt0 in cycle 1, done0 in cycle 5 (ACCESS_LAT=4), rdata=5, mem_wr_en never high.
- Write then read: req1 write addr 12 data 0xDEADBEEF -> mem_wr_en high exactly one cycle (cycle 4). Subsequent req1 read addr 12 -> rdata=0xDEADBEEF.
- Simultaneous requests: req0 and req1 both held from reset -> gnt0 first, then gnt1. Both requesting again -> gnt0 (alternation), with no gnt overlap.
- Out of range: req0 read addr 1024 -> done0 with resp_err=1 two cycles after the request edge; mem_wr_en stays 0; rdata unchanged.
- Reset mid-write: rst_n low during cycle 2 of a write to addr 7 -> outputs 0, mem_wr_en never high, mem[7] unchanged, no done. After release, req1 alone is granted.
- MEM_ARB_STATS_EN with CNT_WIDTH=2: five req0 grants -> gcnt0=3 (saturated), gcnt1=0.
